// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch port, the data port and the shared memory.
// master is the arbiter's view; slave is the view of the clients and memory around it.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one memory between instruction fetch and data access.
// Data wins ties unless a waiting fetch has already been passed over STARVE_MAX times.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.master bus,
    output logic               busy
);
    localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

    typedef enum logic [2:0] {StIdle, StBusyIf, StBusyD, StRespIf, StRespD} state_e;

    state_e            state_q, state_d;
    logic              grant_if, grant_d;
    logic [CntW-1:0]   starve_cnt_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    always_comb begin
        state_d  = state_q;
        grant_if = 1'b0;
        grant_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.d_req && (!bus.if_req || (starve_cnt_q < StarveMax))) begin
                    grant_d = 1'b1;
                    state_d = StBusyD;
                end else if (bus.if_req) begin
                    grant_if = 1'b1;
                    state_d  = StBusyIf;
                end
            end
            StBusyIf: if (bus.mem_ack) state_d = StRespIf;
            StBusyD:  if (bus.mem_ack) state_d = StRespD;
            StRespIf, StRespD: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            if (grant_d) begin
                mem_we_q    <= bus.d_we;
                mem_addr_q  <= bus.d_addr;
                mem_wdata_q <= bus.d_wdata;
                // Only data grants that overtake a waiting fetch count towards starvation.
                if (bus.if_req && (starve_cnt_q != StarveMax)) begin
                    starve_cnt_q <= starve_cnt_q + CntW'(1);
                end
            end
            if (grant_if) begin
                mem_we_q     <= 1'b0;
                mem_addr_q   <= bus.if_addr;
                mem_wdata_q  <= '0;
                starve_cnt_q <= '0;
            end
            if ((state_q == StBusyIf) && bus.mem_ack) if_rdata_q <= bus.mem_rdata;
            if ((state_q == StBusyD) && bus.mem_ack && !mem_we_q) d_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.mem_req   = (state_q == StBusyIf) || (state_q == StBusyD);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_ready  = (state_q == StRespIf);
    assign bus.d_ready   = (state_q == StRespD);
    assign busy          = (state_q != StIdle);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a cycle-scheduled transaction model.
module tb_mem_port_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SM = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Expected rdata registers, updated from the data the bench itself returned.
    logic [31:0] exp_if = '0;
    logic [31:0] exp_d  = '0;

    // Results recorded by run_txns.
    logic [31:0] g_addr[$];
    logic [31:0] g_wdata[$];
    bit          g_we[$];
    int          g_k[$];
    bit          r_kind[$];  // 1 = data ready, 0 = fetch ready
    int          r_k[$];
    int          unstable, overlap;
    bit          timeout;

    task automatic clear_inputs();
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    endtask

    // Plays memory with fixed ack latency until n completions; records grants and readies.
    task automatic run_txns(input int n, input int lat, input bit keep_if, input bit keep_d,
                            input int max_cyc);
        int done_n = 0;
        int waitc = 0;
        bit acked = 1'b0;
        bit prev_req = 1'b0;
        logic [31:0] ack_data = '0;
        logic [31:0] l_addr = '0, l_wdata = '0;
        bit l_we = 1'b0;
        g_addr.delete(); g_wdata.delete(); g_we.delete(); g_k.delete();
        r_kind.delete(); r_k.delete();
        unstable = 0; overlap = 0; timeout = 1'b0;
        for (int k = 0; k < max_cyc && done_n < n; k++) begin
            @(negedge clk);
            if (bus.mem_req && !prev_req) begin
                g_addr.push_back(bus.mem_addr); g_wdata.push_back(bus.mem_wdata);
                g_we.push_back(bus.mem_we); g_k.push_back(k);
                l_addr = bus.mem_addr; l_wdata = bus.mem_wdata; l_we = bus.mem_we;
            end else if (bus.mem_req && prev_req) begin
                if (bus.mem_addr !== l_addr || bus.mem_wdata !== l_wdata || bus.mem_we !== l_we)
                    unstable++;
            end
            if ((bus.if_ready || bus.d_ready) && bus.mem_req) overlap++;
            if (bus.if_ready || bus.d_ready) begin
                done_n++;
                r_kind.push_back(bus.d_ready); r_k.push_back(k);
                if (bus.if_ready) exp_if = ack_data;
                if (bus.d_ready && !bus.d_we) exp_d = ack_data;
                if (bus.if_ready && (!keep_if || done_n == n)) bus.if_req = 1'b0;
                if (bus.d_ready && (!keep_d || done_n == n)) bus.d_req = 1'b0;
            end
            bus.mem_ack = 1'b0;
            if (!bus.mem_req) begin
                acked = 1'b0; waitc = 0;
            end else if (!acked) begin
                if (waitc == lat) begin
                    bus.mem_ack = 1'b1; bus.mem_rdata = $urandom; ack_data = bus.mem_rdata;
                    acked = 1'b1;
                end else waitc++;
            end
            prev_req = bus.mem_req;
        end
        if (done_n < n) timeout = 1'b1;
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
        n_cmp++; if (bus.if_ready !== 1'b0) begin n_err++; $display("FAIL reset_if_ready: got %b want 0", bus.if_ready); end
        n_cmp++; if (bus.d_ready !== 1'b0) begin n_err++; $display("FAIL reset_d_ready: got %b want 0", bus.d_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        n_cmp++; if (bus.mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
        n_cmp++; if (bus.if_rdata !== 32'h0) begin n_err++; $display("FAIL reset_if_rdata: got %h want 0", bus.if_rdata); end
        n_cmp++; if (bus.d_rdata !== 32'h0) begin n_err++; $display("FAIL reset_d_rdata: got %h want 0", bus.d_rdata); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_after: got busy %b want 0", busy); end
    endtask

    task automatic test_fetch_only();
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        @(negedge clk);
        n_cmp++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL fetch_req_rise: got %b want 1", bus.mem_req); end
        n_cmp++; if (bus.mem_addr !== 32'h100) begin n_err++; $display("FAIL fetch_addr: got %h want 100", bus.mem_addr); end
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL fetch_we_1: got %b want 0", bus.mem_we); end
        n_cmp++; if (bus.if_ready !== 1'b0) begin n_err++; $display("FAIL fetch_early_ready: got %b want 0", bus.if_ready); end
        @(negedge clk);
        n_cmp++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL fetch_req_hold: got %b want 1", bus.mem_req); end
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL fetch_we_2: got %b want 0", bus.mem_we); end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0050_0093;
        @(negedge clk);
        n_cmp++; if (bus.if_ready !== 1'b1) begin n_err++; $display("FAIL fetch_ready: got %b want 1", bus.if_ready); end
        n_cmp++; if (bus.if_rdata !== 32'h0050_0093) begin n_err++; $display("FAIL fetch_rdata: got %h want 00500093", bus.if_rdata); end
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL fetch_req_fall: got %b want 0", bus.mem_req); end
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL fetch_we_3: got %b want 0", bus.mem_we); end
        bus.mem_ack = 1'b0; bus.if_req = 1'b0;
        exp_if = 32'h0050_0093;
        @(negedge clk);
        n_cmp++; if (bus.if_ready !== 1'b0) begin n_err++; $display("FAIL fetch_ready_once: got %b want 0", bus.if_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fetch_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h2000; bus.d_wdata = 32'h5555_5555;
        run_txns(2, 0, 1'b0, 1'b0, 30);
        n_cmp++; if (timeout) begin n_err++; $display("FAIL simul_timeout: got %0d readies want 2", r_k.size()); end
        if (g_addr.size() >= 2 && r_kind.size() >= 2) begin
            n_cmp++; if (g_addr[0] !== 32'h2000) begin n_err++; $display("FAIL simul_first_addr: got %h want 2000", g_addr[0]); end
            n_cmp++; if (r_kind[0] !== 1'b1) begin n_err++; $display("FAIL simul_first_kind: got %b want 1 (data)", r_kind[0]); end
            n_cmp++; if (g_addr[1] !== 32'h300) begin n_err++; $display("FAIL simul_second_addr: got %h want 300", g_addr[1]); end
            n_cmp++; if (r_kind[1] !== 1'b0) begin n_err++; $display("FAIL simul_second_kind: got %b want 0 (fetch)", r_kind[1]); end
            n_cmp++; if (r_k[0] - g_k[0] !== 1) begin n_err++; $display("FAIL simul_latency: got %0d want 1", r_k[0] - g_k[0]); end
        end
        n_cmp++; if (overlap !== 0) begin n_err++; $display("FAIL simul_overlap: got %0d want 0", overlap); end
        n_cmp++; if (bus.d_rdata !== exp_d) begin n_err++; $display("FAIL simul_d_rdata: got %h want %h", bus.d_rdata, exp_d); end
        n_cmp++; if (bus.if_rdata !== exp_if) begin n_err++; $display("FAIL simul_if_rdata: got %h want %h", bus.if_rdata, exp_if); end
    endtask

    task automatic test_starvation();
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h400;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h3000;
        run_txns(2 * (SM + 1), 0, 1'b1, 1'b1, 80);
        n_cmp++; if (timeout) begin n_err++; $display("FAIL starve_timeout: got %0d readies want %0d", r_k.size(), 2 * (SM + 1)); end
        for (int i = 0; i < r_kind.size(); i++) begin
            n_cmp++;
            if (r_kind[i] !== ((i % (SM + 1)) != SM)) begin
                n_err++; $display("FAIL starve_order[%0d]: got kind %b want %b", i, r_kind[i], (i % (SM + 1)) != SM);
            end
        end
        for (int i = 0; i + 1 < g_k.size(); i++) begin
            n_cmp++;
            if (g_k[i + 1] - g_k[i] !== 3) begin
                n_err++; $display("FAIL starve_throughput[%0d]: got spacing %0d want 3", i, g_k[i + 1] - g_k[i]);
            end
        end
        n_cmp++; if (bus.if_rdata !== exp_if) begin n_err++; $display("FAIL starve_if_rdata: got %h want %h", bus.if_rdata, exp_if); end
        n_cmp++; if (bus.d_rdata !== exp_d) begin n_err++; $display("FAIL starve_d_rdata: got %h want %h", bus.d_rdata, exp_d); end
    endtask

    task automatic test_store();
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEAD_BEEF;
        run_txns(1, 2, 1'b0, 1'b0, 20);
        bus.d_we = 1'b0;
        n_cmp++; if (timeout) begin n_err++; $display("FAIL store_timeout: got 0 readies want 1"); end
        if (g_addr.size() >= 1 && r_kind.size() >= 1) begin
            n_cmp++; if (g_we[0] !== 1'b1) begin n_err++; $display("FAIL store_we: got %b want 1", g_we[0]); end
            n_cmp++; if (g_wdata[0] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL store_wdata: got %h want deadbeef", g_wdata[0]); end
            n_cmp++; if (g_addr[0] !== 32'h40) begin n_err++; $display("FAIL store_addr: got %h want 40", g_addr[0]); end
            n_cmp++; if (r_kind[0] !== 1'b1) begin n_err++; $display("FAIL store_ready_kind: got %b want 1", r_kind[0]); end
            n_cmp++; if (r_k[0] - g_k[0] !== 3) begin n_err++; $display("FAIL store_latency: got %0d want 3", r_k[0] - g_k[0]); end
        end
        n_cmp++; if (unstable !== 0) begin n_err++; $display("FAIL store_stable: got %0d changes want 0", unstable); end
        n_cmp++; if (bus.d_rdata !== exp_d) begin n_err++; $display("FAIL store_d_rdata_kept: got %h want %h", bus.d_rdata, exp_d); end
    endtask

    task automatic test_spurious();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFF0 + 32'(i);
            @(negedge clk);
            bus.mem_ack = 1'b0;
            n_cmp++; if (bus.if_ready !== 1'b0 || bus.d_ready !== 1'b0) begin n_err++; $display("FAIL spur_ready[%0d]: got %b%b want 00", i, bus.if_ready, bus.d_ready); end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL spur_busy[%0d]: got %b want 0", i, busy); end
        end
        n_cmp++; if (bus.if_rdata !== exp_if) begin n_err++; $display("FAIL spur_if_rdata: got %h want %h", bus.if_rdata, exp_if); end
        n_cmp++; if (bus.d_rdata !== exp_d) begin n_err++; $display("FAIL spur_d_rdata: got %h want %h", bus.d_rdata, exp_d); end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            seen = bus.mem_req;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL rstmid_grant: got no mem_req want 1"); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rstmid_req_fall: got %b want 0", bus.mem_req); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (bus.d_rdata !== 32'h0) begin n_err++; $display("FAIL rstmid_d_rdata: got %h want 0", bus.d_rdata); end
        exp_if = '0; exp_d = '0;
        @(negedge clk);
        n_cmp++; if (bus.d_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_no_ready: got %b want 0", bus.d_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL rstmid_regrant: got %b want 1", bus.mem_req); end
        n_cmp++; if (bus.mem_addr !== 32'h80) begin n_err++; $display("FAIL rstmid_addr: got %h want 80", bus.mem_addr); end
        n_cmp++; if (bus.d_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_no_ready2: got %b want 0", bus.d_ready); end
        run_txns(1, 1, 1'b0, 1'b0, 20);
        n_cmp++; if (timeout || r_kind.size() < 1) begin n_err++; $display("FAIL rstmid_complete: got no ready want d_ready"); end
        n_cmp++; if (bus.d_rdata !== exp_d) begin n_err++; $display("FAIL rstmid_load_data: got %h want %h", bus.d_rdata, exp_d); end
    endtask

    // Model: a transaction chosen at an idle cycle c shows mem_req from c+1 until its ack,
    // ready the cycle after the ack, and the arbiter is free again one cycle later.
    task automatic test_random();
        bit act = 1'b0, t_d = 1'b0, t_we = 1'b0, acked = 1'b0;
        bit exp_req, exp_ifr, exp_dr, obs_ifr, obs_dr;
        logic [31:0] t_addr = '0, t_wdata = '0, m_if = '0, m_d = '0;
        int g_c = 0, a_c = -1, starve = 0, lat = 0, waitc = 0;
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (act && a_c >= 0 && c == a_c + 2) act = 1'b0;
            exp_req = act && c >= g_c && a_c < 0;
            exp_ifr = act && a_c >= 0 && c == a_c + 1 && !t_d;
            exp_dr  = act && a_c >= 0 && c == a_c + 1 && t_d;
            n_cmp++; if (bus.mem_req !== exp_req) begin n_err++; $display("FAIL rnd_mem_req c%0d: got %b want %b", c, bus.mem_req, exp_req); end
            n_cmp++; if (busy !== act) begin n_err++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, act); end
            if (exp_req) begin
                n_cmp++;
                if (bus.mem_addr !== t_addr || bus.mem_we !== t_we || bus.mem_wdata !== t_wdata) begin
                    n_err++; $display("FAIL rnd_fields c%0d: got %h/%b/%h want %h/%b/%h", c, bus.mem_addr,
                                      bus.mem_we, bus.mem_wdata, t_addr, t_we, t_wdata);
                end
            end
            n_cmp++; if (bus.if_ready !== exp_ifr) begin n_err++; $display("FAIL rnd_if_ready c%0d: got %b want %b", c, bus.if_ready, exp_ifr); end
            n_cmp++; if (bus.d_ready !== exp_dr) begin n_err++; $display("FAIL rnd_d_ready c%0d: got %b want %b", c, bus.d_ready, exp_dr); end
            n_cmp++; if (bus.if_rdata !== m_if) begin n_err++; $display("FAIL rnd_if_rdata c%0d: got %h want %h", c, bus.if_rdata, m_if); end
            n_cmp++; if (bus.d_rdata !== m_d) begin n_err++; $display("FAIL rnd_d_rdata c%0d: got %h want %h", c, bus.d_rdata, m_d); end
            // Clients: after a completion either re-request at once or drop.
            obs_ifr = bus.if_ready; obs_dr = bus.d_ready;
            if (obs_ifr) begin
                if ($urandom_range(1) == 1) bus.if_addr = $urandom; else bus.if_req = 1'b0;
            end else if (!bus.if_req && $urandom_range(3) == 0) begin
                bus.if_req = 1'b1; bus.if_addr = $urandom;
            end
            if (obs_dr) begin
                if ($urandom_range(1) == 1) begin
                    bus.d_we = 1'($urandom_range(1)); bus.d_addr = $urandom; bus.d_wdata = $urandom;
                end else bus.d_req = 1'b0;
            end else if (!bus.d_req && $urandom_range(2) == 0) begin
                bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(1));
                bus.d_addr = $urandom; bus.d_wdata = $urandom;
            end
            // Memory: random latency, plus stray acks whenever no request is outstanding.
            bus.mem_ack = 1'b0;
            if (!bus.mem_req) begin
                acked = 1'b0; waitc = 0;
                if ($urandom_range(7) == 0) begin bus.mem_ack = 1'b1; bus.mem_rdata = $urandom; end
            end else if (!acked) begin
                if (waitc >= lat) begin
                    bus.mem_ack = 1'b1; bus.mem_rdata = $urandom; acked = 1'b1;
                    lat = $urandom_range(3);
                    if (act) begin
                        a_c = c;
                        if (!t_d) m_if = bus.mem_rdata;
                        else if (!t_we) m_d = bus.mem_rdata;
                    end
                end else waitc++;
            end
            if (!act && (bus.if_req || bus.d_req)) begin
                t_d = bus.d_req && (!bus.if_req || starve < int'(SM));
                if (t_d) begin
                    t_we = bus.d_we; t_addr = bus.d_addr; t_wdata = bus.d_wdata;
                    if (bus.if_req && starve < int'(SM)) starve++;
                end else begin
                    t_we = 1'b0; t_addr = bus.if_addr; t_wdata = '0; starve = 0;
                end
                act = 1'b1; g_c = c + 1; a_c = -1;
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_starvation();
        test_store();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, maximum consecutive data grants while a fetch waits.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port if_req  input  1  fetch request level, held until if_ready.
REQ-007 SHALL have port if_addr  input  ADDR_W  fetch address, stable while if_req is high.
REQ-008 SHALL have port if_rdata  output  DATA_W  registered fetch data.
REQ-009 SHALL have port if_ready  output  1  one-cycle fetch completion pulse.
REQ-010 SHALL have port d_req  input  1  data request level, held until d_ready.
REQ-011 SHALL have port d_we  input  1  data write enable: 1 = store, 0 = load.
REQ-012 SHALL have port d_addr  input  ADDR_W  data address.
REQ-013 SHALL have port d_wdata  input  DATA_W  store data.
REQ-014 SHALL have port d_rdata  output  DATA_W  registered load data.
REQ-015 SHALL have port d_ready  output  1  one-cycle data completion pulse.
REQ-016 SHALL have port mem_req  output  1  memory request, held until mem_ack.
REQ-017 SHALL have ports mem_we (output, 1), mem_addr (output, ADDR_W) and mem_wdata (output, DATA_W): the latched transaction fields.
REQ-018 SHALL have port mem_rdata  input  DATA_W  memory read data, valid when mem_ack is high.
REQ-019 SHALL have port mem_ack  input  1  memory completion, any latency of 0 or more cycles.
REQ-020 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-021 SHALL implement the states IDLE, BUSY_IF, BUSY_D, RESP_IF and RESP_D.
REQ-022 In IDLE, SHALL grant data (go to BUSY_D) when d_req is high and either if_req is low or starve_cnt is below STARVE_MAX.
REQ-023 In IDLE, SHALL otherwise grant fetch (go to BUSY_IF) when if_req is high; with no request, SHALL stay in IDLE.
REQ-024 On grant, SHALL latch the granted requester's addr, we and wdata into the mem_* registers; fetch grants SHALL force mem_we to 0 and mem_wdata to 0.
REQ-025 In BUSY_x, SHALL hold mem_req at 1 with the mem_* fields stable; mem_req SHALL be 0 in every other state.
REQ-026 In BUSY_x with mem_ack high, SHALL go to RESP_x; for a fetch or a load, SHALL capture mem_rdata into if_rdata or d_rdata respectively.
REQ-027 On a store, d_rdata SHALL keep its previous value.
REQ-028 In RESP_x, SHALL assert x_ready for exactly one cycle, SHALL make no new grant, and SHALL go to IDLE on the next edge.
REQ-029 Latency: a request sampled in IDLE at cycle t gives mem_req high from t+1, ack at t+1+L, and x_ready at t+2+L.
REQ-030 Minimum latency (L=0) SHALL be ready at t+2; maximum throughput SHALL be one transaction per 3 cycles.
REQ-031 starve_cnt SHALL increment, saturating at STARVE_MAX, on each data grant made while if_req is high.
REQ-032 starve_cnt SHALL clear to 0 on each fetch grant, and SHALL hold otherwise.
REQ-033 mem_ack in IDLE or RESP_x SHALL be ignored, with no state or data change.
REQ-034 if_rdata and d_rdata SHALL hold between completions.
REQ-035 Addresses SHALL pass through unmodified, with no alignment checking.

Reset
REQ-036 While rst_n is 0, SHALL force state IDLE and set mem_req, mem_we, if_ready, d_ready and busy to 0.
REQ-037 While rst_n is 0, SHALL clear starve_cnt, mem_addr, mem_wdata, if_rdata and d_rdata to 0.
REQ-038 Reset asserted mid-transaction SHALL abort it with no ready pulse; after release, a still-high request SHALL be re-arbitrated from IDLE.

Verification
REQ-039 Fetch-only test: if_req=1, if_addr=0x100, mem_ack one cycle after mem_req rises, mem_rdata=0x00500093 -> if_ready pulses at t+3 with if_rdata=0x00500093, and mem_we=0 throughout.
REQ-040 Simultaneous request test: if_req=1 and d_req=1 (load, d_addr=0x2000) in the same cycle -> data served first, then fetch, with no overlapping mem_req.
REQ-041 Starvation test: if_req held at 1 and d_req re-asserted immediately after each d_ready, STARVE_MAX=4 -> exactly 4 data grants, then a fetch grant, with starve_cnt returning to 0.
REQ-042 Store test: d_we=1, d_wdata=0xDEADBEEF, d_addr=0x40 -> mem_we=1 and mem_wdata=0xDEADBEEF while mem_req is high, d_ready pulses, and d_rdata is unchanged.
REQ-043 Spurious-ack test: mem_ack pulsed in IDLE -> no ready pulse and no change to the rdata registers.
REQ-044 Reset test: rst_n driven low in BUSY_D with mem_ack withheld -> mem_req falls immediately, no d_ready pulse, and after release a held d_req is re-granted.
